sync_edge_filter: RTL and testbench
===================================

SYNC_EDGE_FILTER -- requirements
Module: sync_edge_filter

Interface
REQ-001 SHALL have parameter INIT_VALUE, default 1'b0: the value of `level` at reset.
REQ-002 SHALL have parameter FILTER_CYCLES, default 3: the number of consecutive cycles `in` must differ from `level` before `level` changes; legal range 1..255.
REQ-003 SHALL have parameter CNT_W, default 8: the width of the event counter; legal range 2..32.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is in this domain.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in, input, 1 bit: a level already synchronized to clk by the upstream synchronizer stage; no further synchronization is done here.
REQ-007 SHALL have port cnt_clr, input, 1 bit: synchronous clear of the event counter and saturation flag.
REQ-008 SHALL have port level, output, 1 bit: the filtered (deglitched) level, registered.
REQ-009 SHALL have port rise, output, 1 bit: a one-cycle pulse on each 0->1 change of `level`, registered.
REQ-010 SHALL have port fall, output, 1 bit: a one-cycle pulse on each 1->0 change of `level`, registered.
REQ-011 SHALL have port evt_cnt, output, CNT_W bits: the number of `rise` events since reset or clear.
REQ-012 SHALL have port cnt_sat, output, 1 bit: sticky flag, set when a rise arrives while evt_cnt is all-ones.

Function
REQ-013 SHALL implement a two-state FSM: STABLE and CHECK.
REQ-014 In STABLE with in==level, SHALL stay in STABLE with the timer held at 0.
REQ-015 In STABLE with in!=level, SHALL set timer=1; if FILTER_CYCLES==1, SHALL toggle `level` at this edge and stay in STABLE, otherwise SHALL go to CHECK.
REQ-016 In CHECK with in==level, SHALL return to STABLE with timer=0, leaving `level` unchanged (glitch rejected, no pulse).
REQ-017 In CHECK with in!=level and timer==FILTER_CYCLES-1, SHALL toggle `level`, clear the timer and go to STABLE.
REQ-018 In CHECK with in!=level and timer<FILTER_CYCLES-1, SHALL increment the timer and stay in CHECK.
REQ-019 Latency: `level` SHALL change on the FILTER_CYCLES-th consecutive rising edge at which in!=level was sampled.
REQ-020 `rise` and `fall` SHALL assert in the same cycle as the new `level` value, for exactly one cycle; they SHALL never assert together.
REQ-021 Timer width SHALL be clog2(FILTER_CYCLES+1); the timer SHALL never exceed FILTER_CYCLES-1.
REQ-022 The counter SHALL increment by 1 on each `rise`; it SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-023 A `rise` arriving at saturation SHALL set `cnt_sat`, which stays set until cleared.
REQ-024 cnt_clr alone SHALL make evt_cnt=0 and cnt_sat=0 on the next edge.
REQ-025 cnt_clr coinciding with a rise SHALL make evt_cnt=1 and cnt_sat=0 (the event is not lost).
REQ-026 cnt_clr SHALL have no effect on the filter, `level`, `rise` or `fall`.

Reset
REQ-027 On rst_n low, asynchronously: level=INIT_VALUE, rise=0, fall=0, state=STABLE, timer=0, evt_cnt=0, cnt_sat=0.
REQ-028 Reset asserted during CHECK SHALL abandon the pending transition; no pulse SHALL be produced on reset exit.
REQ-029 After rst_n deasserts, the first filtering evaluation SHALL occur on the first rising edge of clk.

Configuration
REQ-030 The macro SYNC_EDGE_FILTER_CNT_EN SHALL control the event counter.
REQ-031 With SYNC_EDGE_FILTER_CNT_EN defined, the counter SHALL be built and SHALL behave per REQ-022..REQ-026.
REQ-032 Without SYNC_EDGE_FILTER_CNT_EN: evt_cnt SHALL be tied to 0, cnt_sat tied to 0, cnt_clr ignored and no counter flops present; the port list SHALL be unchanged.

Verification
REQ-033 Glitch rejection: FILTER_CYCLES=3, in=1 for 2 cycles then 0 -> level stays 0, and rise and fall stay 0.
REQ-034 Accepted edge: FILTER_CYCLES=3, in 0->1 held -> level=1 and rise=1 on the 3rd edge after the change, rise=0 on the next cycle, evt_cnt=1.
REQ-035 Bypass case: FILTER_CYCLES=1, in toggling every 2 cycles -> level follows in one cycle later; rise and fall alternate, one cycle each.
REQ-036 Saturation: CNT_W=2, 5 accepted rises -> evt_cnt=3 and cnt_sat=1 after the 4th rise; cnt_clr then -> evt_cnt=0, cnt_sat=0.
REQ-037 Clear with rise: cnt_clr in the same cycle as a rise with evt_cnt=2 -> evt_cnt=1, cnt_sat=0.
REQ-038 Reset mid-CHECK: INIT_VALUE=1, in=0 for 2 of 3 cycles, rst_n pulsed low -> level=1, no fall; after release with in=0, fall occurs 3 edges later.

Source files
------------

// File: rtl/sync_edge_filter.sv
// Deglitching filter for an already-synchronized level, with rise/fall pulses
// and an optional saturating rise counter built only when SYNC_EDGE_FILTER_CNT_EN is defined.
module sync_edge_filter #(
    parameter logic INIT_VALUE    = 1'b0,
    parameter int   FILTER_CYCLES = 3,
    parameter int   CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in,
    input  logic             cnt_clr,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] evt_cnt,
    output logic             cnt_sat
);

    localparam int TW = $clog2(FILTER_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(FILTER_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

    typedef enum logic {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            level_q, level_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STABLE;
            timer_q <= '0;
            level_q <= INIT_VALUE;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            STABLE: begin
                if (in != level_q) begin
                    if (FILTER_CYCLES == 1) begin
                        // Single-cycle filter: accept immediately; timer stays at its 0 ceiling.
                        level_d = ~level_q;
                        rise_d  = ~level_q;
                        fall_d  = level_q;
                        timer_d = '0;
                    end else begin
                        timer_d = TIMER_ONE;
                        state_d = CHECK;
                    end
                end else begin
                    timer_d = '0;
                end
            end
            CHECK: begin
                if (in == level_q) begin
                    state_d = STABLE;
                    timer_d = '0;
                end else if (timer_q == TIMER_LAST) begin
                    level_d = ~level_q;
                    rise_d  = ~level_q;
                    fall_d  = level_q;
                    timer_d = '0;
                    state_d = STABLE;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            default: begin
                state_d = STABLE;
                timer_d = '0;
            end
        endcase
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

`ifdef SYNC_EDGE_FILTER_CNT_EN
    // Counts on the same edge that raises `rise`, so evt_cnt and rise update together;
    // a clear sampled on that edge still records the new event.
    logic [CNT_W-1:0] cnt_q;
    logic             sat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else if (cnt_clr) begin
            cnt_q <= rise_d ? CNT_W'(1) : '0;
            sat_q <= 1'b0;
        end else if (rise_d) begin
            if (&cnt_q) begin
                sat_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign evt_cnt = cnt_q;
    assign cnt_sat = sat_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign evt_cnt        = '0;
    assign cnt_sat        = 1'b0;
`endif

endmodule

// File: tb/tb_sync_edge_filter.sv
// Directed bench for sync_edge_filter: table-driven sequence on a 3-cycle filter with a
// 2-bit counter, plus hand sequences for the 1-cycle bypass and reset during CHECK.
module tb_sync_edge_filter;

    logic clk;
    logic a_rst_n, a_in, a_clr, a_level, a_rise, a_fall, a_sat;
    logic [1:0] a_cnt;
    logic b_rst_n, b_in, b_clr, b_level, b_rise, b_fall, b_sat;
    logic [7:0] b_cnt;
    logic c_rst_n, c_in, c_clr, c_level, c_rise, c_fall, c_sat;
    logic [7:0] c_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       in;
        logic       clr;
        logic       lvl;
        logic       r;
        logic       f;
        logic [1:0] cnt;
        logic       sat;
    } vec_t;

    vec_t vecs[$];

    sync_edge_filter #(.INIT_VALUE(1'b0), .FILTER_CYCLES(3), .CNT_W(2)) u_a (
        .clk(clk), .rst_n(a_rst_n), .in(a_in), .cnt_clr(a_clr),
        .level(a_level), .rise(a_rise), .fall(a_fall), .evt_cnt(a_cnt), .cnt_sat(a_sat)
    );

    sync_edge_filter #(.INIT_VALUE(1'b0), .FILTER_CYCLES(1), .CNT_W(8)) u_b (
        .clk(clk), .rst_n(b_rst_n), .in(b_in), .cnt_clr(b_clr),
        .level(b_level), .rise(b_rise), .fall(b_fall), .evt_cnt(b_cnt), .cnt_sat(b_sat)
    );

    sync_edge_filter #(.INIT_VALUE(1'b1), .FILTER_CYCLES(3), .CNT_W(8)) u_c (
        .clk(clk), .rst_n(c_rst_n), .in(c_in), .cnt_clr(c_clr),
        .level(c_level), .rise(c_rise), .fall(c_fall), .evt_cnt(c_cnt), .cnt_sat(c_sat)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter expectations collapse to 0 when the counter is not built.
    function automatic logic [31:0] ce(input logic [31:0] v);
`ifdef SYNC_EDGE_FILTER_CNT_EN
        return v;
`else
        return 32'd0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic i, input logic clr, input logic lvl, input logic r,
                       input logic f, input logic [1:0] cnt, input logic sat);
        vecs.push_back('{i, clr, lvl, r, f, cnt, sat});
    endtask

    task automatic check_a(input string tag, input vec_t v);
        check({tag, ".level"}, {31'd0, a_level}, {31'd0, v.lvl});
        check({tag, ".rise"},  {31'd0, a_rise},  {31'd0, v.r});
        check({tag, ".fall"},  {31'd0, a_fall},  {31'd0, v.f});
        check({tag, ".evt_cnt"}, {30'd0, a_cnt}, ce({30'd0, v.cnt}));
        check({tag, ".cnt_sat"}, {31'd0, a_sat}, ce({31'd0, v.sat}));
    endtask

    initial begin
        a_rst_n = 1'b0; a_in = 1'b0; a_clr = 1'b0;
        b_rst_n = 1'b0; b_in = 1'b0; b_clr = 1'b0;
        c_rst_n = 1'b0; c_in = 1'b1; c_clr = 1'b0;

        // in        clr lvl rise fall cnt sat
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0); // glitch of two cycles
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0); // accepted rise on 3rd edge
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0); // accepted fall
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0); // one-cycle glitch
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0); // rise 2
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0); // clear coinciding with rise
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0); // rise at all-ones: saturate
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b1);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1); // no wrap, flag sticky
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1);
        add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b1);
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0); // clear alone
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0); // clear does not disturb filter
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);

        // reset values (asynchronous, checked before any edge after assertion)
        #12;
        check("a_rst.level", {31'd0, a_level}, 32'd0);
        check("a_rst.rise",  {31'd0, a_rise},  32'd0);
        check("a_rst.fall",  {31'd0, a_fall},  32'd0);
        check("a_rst.evt_cnt", {30'd0, a_cnt}, 32'd0);
        check("a_rst.cnt_sat", {31'd0, a_sat}, 32'd0);
        check("c_rst.level", {31'd0, c_level}, 32'd1);
        check("c_rst.fall",  {31'd0, c_fall},  32'd0);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        c_rst_n = 1'b1;

        // table-driven sequence on instance A
        for (int i = 0; i < vecs.size(); i++) begin
            a_in  = vecs[i].in;
            a_clr = vecs[i].clr;
            tick();
            check_a($sformatf("vec%0d", i), vecs[i]);
        end
        a_clr = 1'b0;

        // bypass: FILTER_CYCLES=1, input toggling every 2 cycles
        for (int k = 0; k < 3; k++) begin
            b_in = 1'b1;
            tick();
            check($sformatf("byp%0d.rise_lvl", k), {30'd0, b_level, b_rise}, 32'd3);
            check($sformatf("byp%0d.rise_fall", k), {31'd0, b_fall}, 32'd0);
            tick();
            check($sformatf("byp%0d.hold_hi", k), {29'd0, b_level, b_rise, b_fall}, 32'd4);
            b_in = 1'b0;
            tick();
            check($sformatf("byp%0d.fall_lvl", k), {29'd0, b_level, b_rise, b_fall}, 32'd1);
            tick();
            check($sformatf("byp%0d.hold_lo", k), {29'd0, b_level, b_rise, b_fall}, 32'd0);
        end
        check("byp.evt_cnt", {24'd0, b_cnt}, ce(32'd3));
        check("byp.cnt_sat", {31'd0, b_sat}, 32'd0);

        // reset during CHECK abandons the pending fall
        c_in = 1'b0;
        tick();
        check("rc.edge1", {29'd0, c_level, c_rise, c_fall}, 32'd4);
        tick();
        check("rc.edge2", {29'd0, c_level, c_rise, c_fall}, 32'd4);
        c_rst_n = 1'b0;
        #1;
        check("rc.in_reset", {29'd0, c_level, c_rise, c_fall}, 32'd4);
        tick();
        check("rc.held", {29'd0, c_level, c_rise, c_fall}, 32'd4);
        #2;
        c_rst_n = 1'b1;
        tick();
        check("rc.post1", {29'd0, c_level, c_rise, c_fall}, 32'd4);
        tick();
        check("rc.post2", {29'd0, c_level, c_rise, c_fall}, 32'd4);
        tick();
        check("rc.post3", {29'd0, c_level, c_rise, c_fall}, 32'd1);
        tick();
        check("rc.post4", {29'd0, c_level, c_rise, c_fall}, 32'd0);
        check("rc.evt_cnt", {24'd0, c_cnt}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
